// File: rtl/uart_pkg.sv
// Shared UART package: FSM state encoding and default frame constants.
// Used by the transmitter and by the oversampling receiver so both agree on
// the default data width and oversampling ratio.
package uart_pkg;

    localparam int DEF_DBIT    = 8;
    localparam int DEF_OS      = 16;
    localparam int DEF_SB_TICK = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_tx_unit_if.sv
// Host-side handshake of the UART transmitter.
// master: host write logic; slave: the transmitter.
interface uart_tx_if
    import uart_pkg::*;
#(
    parameter int DBIT = DEF_DBIT
);
    logic            tx_start;
    logic [DBIT-1:0] din;
    logic            tx_busy;
    logic            tx_done_tick;

    modport master (output tx_start, din, input tx_busy, tx_done_tick);
    modport slave  (input tx_start, din, output tx_busy, tx_done_tick);
endinterface

// File: rtl/uart_tx_unit.sv
// UART transmitter: start bit, DBIT data bits LSB first, optional parity
// bit, then the stop period. Bit timing comes from the external
// oversampling tick s_tick (OS ticks per bit, SB_TICK ticks of stop).
//
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit after
// the data bits (even parity, or odd when PARITY_ODD=1).
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | line high, waiting for tx_start
// START  | driving start bit (0) for OS ticks
// DATA   | driving shreg[0] for OS ticks per bit, DBIT bits
// PARITY | driving parity of the latched word for OS ticks (optional)
// STOP   | driving stop level (1) for SB_TICK ticks, then done pulse
module uart_tx_unit
    import uart_pkg::*;
#(
    parameter int DBIT       = DEF_DBIT,
    parameter int OS         = DEF_OS,
    parameter int SB_TICK    = DEF_SB_TICK,
    parameter int PARITY_ODD = 0
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      s_tick,
    uart_tx_if.slave  host,
    output logic      tx
);

    localparam int TMAX = (OS > SB_TICK) ? OS : SB_TICK;
    localparam int TW   = $clog2(TMAX);
    localparam int BW   = $clog2(DBIT);

    localparam logic [TW-1:0] OS_LAST   = TW'(OS - 1);
    localparam logic [TW-1:0] STOP_LAST = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DBIT - 1);

    uart_state_t     state, state_n;
    logic [TW-1:0]   tick_cnt, tick_n;
    logic [BW-1:0]   bit_cnt, bit_n;
    logic [DBIT-1:0] shreg, shreg_n;
    logic            tx_reg, tx_n;
    logic            done_reg, done_n;

`ifdef UART_TX_PARITY_EN
    // Parity is taken from a frame-long copy of the word, not the shifter,
    // because the shifter has been emptied by the time the parity bit goes out.
    logic [DBIT-1:0] data_latched, data_n;

    // Latched word for the parity bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) data_latched <= '0;
        else       data_latched <= data_n;
    end
`endif

    // State, counters, shifter and the registered line/done outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx_reg   <= 1'b1;
            done_reg <= 1'b0;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_n;
            bit_cnt  <= bit_n;
            shreg    <= shreg_n;
            tx_reg   <= tx_n;
            done_reg <= done_n;
        end
    end

    // Next-state, counter updates and next line level (from the next state,
    // so tx follows the state with no combinational path to the pin).
    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        done_n  = 1'b0;
        tx_n    = 1'b1;
`ifdef UART_TX_PARITY_EN
        data_n  = data_latched;
`endif

        case (state)
            IDLE: begin
                if (host.tx_start) begin
                    shreg_n = host.din;
                    tick_n  = '0;
                    state_n = START;
`ifdef UART_TX_PARITY_EN
                    data_n  = host.din;
`endif
                end
            end
            START: begin
                if (s_tick) begin
                    if (tick_cnt == OS_LAST) begin
                        tick_n  = '0;
                        bit_n   = '0;
                        state_n = DATA;
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (tick_cnt == OS_LAST) begin
                        tick_n  = '0;
                        shreg_n = shreg >> 1;
                        if (bit_cnt == BIT_LAST) begin
                            bit_n = '0;
`ifdef UART_TX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end else begin
                            bit_n = bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (tick_cnt == OS_LAST) begin
                        tick_n  = '0;
                        state_n = STOP;
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (tick_cnt == STOP_LAST) begin
                        tick_n  = '0;
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            default: begin
                tick_n  = '0;
                bit_n   = '0;
                state_n = IDLE;
            end
        endcase

        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shreg_n[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_n = (^data_n) ^ PARITY_ODD[0];
`endif
            default: tx_n = 1'b1;
        endcase
    end

    assign tx                = tx_reg;
    assign host.tx_done_tick = done_reg;
    assign host.tx_busy      = (state != IDLE);

endmodule
